pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the 5-stage MIPS core. It replaces the single-bubble load-use detector.
- Generates all write-enable, bubble and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Adds a configurable number of load-use bubbles, optional no-forwarding RAW stalls, and a multi-cycle data-memory wait FSM with timeout.
- Sits in stage 2 beside Registers/Eq and drives every pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/hazard_cmp.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// stall-cause codes, memory-wait FSM states and the register address width.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_MEM  = 2'd2,
    CAUSE_HALT = 2'd3
  } stall_cause_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Compares one in-flight destination register against the ID-stage sources.
// Register 0 is hard-wired to zero and therefore never creates a dependence.
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] dst,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic              hit
);

  assign hit = (dst != '0) && (((dst == rs) && use_rs) || ((dst == rt) && use_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: load-use bubbles, optional RAW stalls
// without forwarding, data-memory wait FSM with timeout, and branch flushes.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LU_BUBBLES  = 1,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              ex_memread_i,
  input  logic              ex_regwrite_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              br_taken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              idex_we_o,
  output logic              idex_bubble_o,
  output logic              exmem_we_o,
  output logic              memwb_bubble_o,
  output logic [1:0]        stall_cause_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              err_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  // The detecting cycle is itself the first bubble, so only the remainder is stored.
  localparam logic [1:0] LU_RELOAD = 2'(LU_BUBBLES - 1);

  ctrl_state_e       state, state_nxt;
  stall_cause_e      cause;
  logic [1:0]        lu_cnt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              hit_ex, hit_mem, lu_detect, raw_stall, data_stall;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_ex (
    .dst(ex_rd_i), .rs(id_rs_i), .rt(id_rt_i),
    .use_rs(id_use_rs_i), .use_rt(id_use_rt_i), .hit(hit_ex)
  );

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp_mem (
    .dst(mem_rd_i), .rs(id_rs_i), .rt(id_rt_i),
    .use_rs(id_use_rs_i), .use_rt(id_use_rt_i), .hit(hit_mem)
  );

  assign lu_detect  = (state == ST_RUN) && (lu_cnt == 2'd0) && ex_memread_i && hit_ex;
  assign raw_stall  = (FWD_EN == 0) &&
                      ((ex_regwrite_i && hit_ex) || (mem_regwrite_i && hit_mem));
  assign data_stall = (lu_cnt != 2'd0) || lu_detect || raw_stall;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (dmem_req_i && !dmem_ack_i) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (dmem_ack_i) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // The failed request cycle counts as the first cycle of the wait.
  always_comb begin
    wait_cnt_nxt = '0;
    if (state == ST_RUN) begin
      if (state_nxt == ST_MEM_WAIT) wait_cnt_nxt = WAIT_W'(1);
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt_nxt = wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt_nxt = wait_cnt;
    end
  end

  always_comb begin
    pc_we_o        = 1'b1;
    ifid_we_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_we_o      = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_we_o     = 1'b1;
    memwb_bubble_o = 1'b0;
    cause          = CAUSE_NONE;
    if (!rst_n_i || !start_i) begin
      pc_we_o    = 1'b0;
      ifid_we_o  = 1'b0;
      idex_we_o  = 1'b0;
      exmem_we_o = 1'b0;
      cause      = CAUSE_HALT;
    end else if (state == ST_MEM_WAIT) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      idex_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_bubble_o = 1'b1;
      cause          = CAUSE_MEM;
    end else if (data_stall) begin
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      idex_bubble_o = 1'b1;
      cause         = CAUSE_RAW;
    end else if (br_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  assign stall_cause_o = cause;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_RUN;
      lu_cnt      <= 2'd0;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
      err_o       <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      // lu_cnt only advances while the pipeline is actually moving.
      if (start_i && state == ST_RUN) begin
        if (lu_detect) lu_cnt <= LU_RELOAD;
        else if (lu_cnt != 2'd0) lu_cnt <= lu_cnt - 2'd1;
      end
      if (wait_cnt_nxt == WAIT_MAX) err_o <= 1'b1;
      if ((cause == CAUSE_RAW || cause == CAUSE_MEM) && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with forwarding and one
// without, both with two load-use bubbles and a memory timeout of four cycles.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, ex_memread, ex_regwrite, mem_regwrite;
  logic       br_taken, dmem_req, dmem_ack;

  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, err;
  logic [1:0]  cause;
  logic [15:0] stall_cnt;

  logic        nf_pc_we, nf_ifid_we, nf_ifid_flush, nf_idex_we, nf_idex_bubble;
  logic        nf_exmem_we, nf_memwb_bubble, nf_err;
  logic [1:0]  nf_cause;
  logic [15:0] nf_stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(2), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .ex_memread_i(ex_memread), .ex_regwrite_i(ex_regwrite), .ex_rd_i(ex_rd),
    .mem_regwrite_i(mem_regwrite), .mem_rd_i(mem_rd), .br_taken_i(br_taken),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush), .idex_we_o(idex_we),
    .idex_bubble_o(idex_bubble), .exmem_we_o(exmem_we), .memwb_bubble_o(memwb_bubble),
    .stall_cause_o(cause), .stall_cnt_o(stall_cnt), .err_o(err)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(2), .FWD_EN(0), .MEM_TIMEOUT(4), .CNT_W(16)) dut_nf (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
    .ex_memread_i(ex_memread), .ex_regwrite_i(ex_regwrite), .ex_rd_i(ex_rd),
    .mem_regwrite_i(mem_regwrite), .mem_rd_i(mem_rd), .br_taken_i(br_taken),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .pc_we_o(nf_pc_we), .ifid_we_o(nf_ifid_we), .ifid_flush_o(nf_ifid_flush),
    .idex_we_o(nf_idex_we), .idex_bubble_o(nf_idex_bubble), .exmem_we_o(nf_exmem_we),
    .memwb_bubble_o(nf_memwb_bubble), .stall_cause_o(nf_cause), .stall_cnt_o(nf_stall_cnt),
    .err_o(nf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Return every input to an idle, hazard-free value.
  task automatic applyStimulus();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
    mem_regwrite = 1'b0; mem_rd = 5'd0;
    br_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFree(input string tag);
    checkOutput({tag, ".pc_we"}, 32'(pc_we), 32'd1);
    checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'd0);
    checkOutput({tag, ".cause"}, 32'(cause), 32'd0);
  endtask

  task automatic checkLuStall(input string tag);
    checkOutput({tag, ".pc_we"}, 32'(pc_we), 32'd0);
    checkOutput({tag, ".ifid_we"}, 32'(ifid_we), 32'd0);
    checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'd1);
    checkOutput({tag, ".cause"}, 32'(cause), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    applyStimulus();
    #2;
    checkOutput("rst.cause", 32'(cause), 32'd3);
    checkOutput("rst.pc_we", 32'(pc_we), 32'd0);
    checkOutput("rst.exmem_we", 32'(exmem_we), 32'd0);
    checkOutput("rst.err", 32'(err), 32'd0);
    checkOutput("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("run.idex_we", 32'(idex_we), 32'd1);
    checkOutput("run.exmem_we", 32'(exmem_we), 32'd1);
    checkFree("run");

    tick(); start = 1'b0;
    #3;
    checkOutput("halt.cause", 32'(cause), 32'd3);
    checkOutput("halt.pc_we", 32'(pc_we), 32'd0);
    checkOutput("halt.idex_we", 32'(idex_we), 32'd0);

    // Load-use against rs: two bubbles, then free.
    tick(); start = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    #3 checkLuStall("lu1");
    tick(); ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
    #3 checkLuStall("lu2");
    tick();
    #3 checkFree("lu_done");
    checkOutput("lu_done.stall_cnt", 32'(stall_cnt), 32'd2);

    // x0 never causes a hazard, with or without forwarding.
    tick(); ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #3 checkFree("x0");
    checkOutput("x0.nf_pc_we", 32'(nf_pc_we), 32'd1);

    tick(); applyStimulus(); br_taken = 1'b1;
    #3;
    checkOutput("br.flush", 32'(ifid_flush), 32'd1);
    checkOutput("br.pc_we", 32'(pc_we), 32'd1);
    tick(); br_taken = 1'b0;
    #3 checkOutput("br_off.flush", 32'(ifid_flush), 32'd0);

    // Branch behind a load-use on rt: flush deferred to the first free cycle.
    tick(); br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
    #3 checkLuStall("brlu1");
    checkOutput("brlu1.flush", 32'(ifid_flush), 32'd0);
    tick(); ex_memread = 1'b0; ex_rd = 5'd0;
    #3 checkLuStall("brlu2");
    checkOutput("brlu2.flush", 32'(ifid_flush), 32'd0);
    tick();
    #3;
    checkOutput("brlu3.flush", 32'(ifid_flush), 32'd1);
    checkFree("brlu3");
    checkOutput("brlu3.stall_cnt", 32'(stall_cnt), 32'd4);

    // RAW against MEM: stalls only without forwarding, for one cycle.
    tick(); applyStimulus(); mem_regwrite = 1'b1; mem_rd = 5'd3; id_rt = 5'd3; id_use_rt = 1'b1;
    #3;
    checkOutput("raw.nf_pc_we", 32'(nf_pc_we), 32'd0);
    checkOutput("raw.nf_idex_bubble", 32'(nf_idex_bubble), 32'd1);
    checkOutput("raw.nf_cause", 32'(nf_cause), 32'd1);
    checkFree("raw_fwd");
    tick(); applyStimulus();
    #3;
    checkOutput("raw_done.nf_pc_we", 32'(nf_pc_we), 32'd1);
    checkOutput("raw_done.nf_cause", 32'(nf_cause), 32'd0);

    // Memory wait: five wait cycles, load-use appears during the wait.
    tick(); dmem_req = 1'b1;
    #3 checkFree("mreq");
    for (int i = 1; i <= 5; i++) begin
      tick();
      ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
      dmem_ack = (i == 5);
      #3;
      checkOutput($sformatf("mw%0d.memwb_bubble", i), 32'(memwb_bubble), 32'd1);
      checkOutput($sformatf("mw%0d.pc_we", i), 32'(pc_we), 32'd0);
      checkOutput($sformatf("mw%0d.idex_we", i), 32'(idex_we), 32'd0);
      checkOutput($sformatf("mw%0d.exmem_we", i), 32'(exmem_we), 32'd0);
      checkOutput($sformatf("mw%0d.idex_bubble", i), 32'(idex_bubble), 32'd0);
      checkOutput($sformatf("mw%0d.cause", i), 32'(cause), 32'd2);
      checkOutput($sformatf("mw%0d.err", i), 32'(err), (i >= 4) ? 32'd1 : 32'd0);
    end
    tick(); dmem_req = 1'b0; dmem_ack = 1'b0;
    #3 checkLuStall("mlu1");
    checkOutput("mlu1.memwb_bubble", 32'(memwb_bubble), 32'd0);
    checkOutput("mlu1.err_sticky", 32'(err), 32'd1);
    tick(); ex_memread = 1'b0; ex_rd = 5'd0;
    #3 checkLuStall("mlu2");
    tick();
    #3 checkFree("mlu3");
    checkOutput("mlu3.stall_cnt", 32'(stall_cnt), 32'd11);

    // Asynchronous reset in the middle of a timed-out wait.
    tick(); applyStimulus(); dmem_req = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    #3 checkOutput("pre_rst.err", 32'(err), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst.cause", 32'(cause), 32'd3);
    checkOutput("arst.err", 32'(err), 32'd0);
    checkOutput("arst.stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("arst.memwb_bubble", 32'(memwb_bubble), 32'd0);
    applyStimulus();
    #2 rst_n = 1'b1;
    tick();
    #3;
    checkOutput("post.ifid_we", 32'(ifid_we), 32'd1);
    checkOutput("post.exmem_we", 32'(exmem_we), 32'd1);
    checkOutput("post.memwb_bubble", 32'(memwb_bubble), 32'd0);
    checkFree("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
